booth4_mult_seq: RTL
====================

Name: booth4_mult_seq

Overview:
- Sequential radix-4 Booth multiplier with an internal iteration counter and a start/ready handshake.
- Parametrised in operand width, with a runtime signed/unsigned mode select.
- Produces the full 2*WIDTH product and an overflow flag for truncation to WIDTH bits.
- Sits in the execute-stage multdiv unit; the ALU control issues `start` and waits for `result_ready`.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Latched with the operands.
- multiplicand  input  WIDTH  operand A; latched on an accepted start.
- multiplier  input  WIDTH  operand B; latched on an accepted start.
- busy  output  1  high in CALC and DONE.
- result_ready  output  1  one-cycle pulse when the result is valid.
- product_lo  output  WIDTH  product bits [WIDTH-1:0].
- product_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- overflow  output  1  the product does not fit in WIDTH bits under the latched mode.

Behaviour:
- Reset:
  - state = IDLE; busy = 0; result_ready = 0.
  - product_lo, product_hi, overflow = 0.
  - Internal accumulator and counter = 0.
  - Reset wins over every other input in the same cycle.
- Operand extension:
  - Both operands are extended to EW = WIDTH+2 bits: sign-extended when is_signed=1, zero-extended otherwise.
  - Iteration count N = EW/2 = WIDTH/2 + 1 (17 for WIDTH=32).
- Accumulator:
  - Layout {hi[EW-1:0], lo[EW-1:0], guard}. On start: hi = 0, lo = extended multiplier, guard = 0.
- One iteration per CALC cycle:
  - Booth triplet = {lo[1], lo[0], guard}.
  - Triplet selects the addend to hi: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M. M is the extended multiplicand.
  - Subtraction is done as invert + carry-in; the sum is EW bits.
  - The whole accumulator is then arithmetic-shifted right by 2.
- FSM:
  - IDLE: start=1 -> latch operands and is_signed, counter = 0, go to CALC. start=0 -> stay.
  - CALC: perform one iteration; counter++. After the iteration with counter == N-1, go to DONE.
  - DONE:
    - result_ready = 1 for exactly this cycle.
    - product_hi/product_lo are registered from the low 2*WIDTH bits of {hi, lo} on the CALC->DONE edge, so they are valid throughout DONE.
    - Next state is always IDLE.
- Latency: start accepted in cycle t -> result_ready high in cycle t+N+1; a new start is accepted no earlier than t+N+2.
- Output hold: product_lo, product_hi and overflow hold their last value until the next DONE or reset. They do not change on start.
- Overflow:
  - is_signed=1: overflow = 1 unless product_hi is all copies of product_lo[WIDTH-1].
  - is_signed=0: overflow = (product_hi != 0).
  - Registered alongside the product.
- start while busy (CALC or DONE): ignored, no queuing. Operand input changes during CALC have no effect.
- Reset mid-operation: the computation is abandoned, state returns to IDLE, and no result_ready is produced.
- Any operand equal to 0 -> product 0, overflow 0, same latency as any other operands (no early exit).

Test Plan:
- WIDTH=32, signed, 7 * -3 -> product_hi=0xFFFFFFFF, product_lo=0xFFFFFFEB, overflow=0, result_ready exactly at t+18.
- WIDTH=32, unsigned, 0xFFFFFFFF * 0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001, overflow=1.
- WIDTH=32, signed, 0x80000000 * 0xFFFFFFFF (-2^31 * -1) -> product_hi=0x00000000, product_lo=0x80000000, overflow=1. The same operands unsigned -> product_hi=0x7FFFFFFF, product_lo=0x80000000, overflow=1.
- Handshake:
  - Pulse start again at t+5 with different operands -> ignored; result matches the first operands.
  - Start asserted continuously -> accepted every N+2 cycles.
  - busy is high from t+1 through t+N+1.
- Reset at t+9 of an operation -> busy=0, outputs 0 next cycle, no result_ready. A fresh start then gives correct results (12 * 12 = 144, overflow=0).
- WIDTH=8, signed, 0x80 * 0x80 (-128 * -128) -> product_hi=0x40, product_lo=0x00, overflow=1, result_ready at t+6. Unsigned 0x0F * 0x11 -> product_hi=0x00, product_lo=0xFF, overflow=0.

Source files
------------

// File: rtl/booth4_mult_seq_if.sv
// booth4_mult_seq_if: start/ready handshake, operands and product of the Booth multiplier
interface booth4_mult_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             result_ready;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             overflow;
  modport master(output start, is_signed, multiplicand, multiplier,
                 input busy, result_ready, product_lo, product_hi, overflow);
  modport slave(input start, is_signed, multiplicand, multiplier,
                output busy, result_ready, product_lo, product_hi, overflow);
endinterface

// File: rtl/booth4_mult_seq.sv
// booth4_mult_seq: sequential radix-4 Booth multiplier, one digit per cycle, start/ready handshake
module booth4_mult_seq #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  booth4_mult_seq_if.slave bus
);
  localparam int EW = WIDTH + 2;
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state, w_next;
  logic [EW-1:0]    r_hi, r_lo, r_m;
  logic             r_g, r_signed, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_plo, r_phi;
  logic [2:0]       w_trip;
  logic             w_zero, w_neg, w_two, w_last, w_ovf;
  logic [EW-1:0]    w_sel, w_add, w_sum, w_hi, w_lo, w_ma, w_mb;
  logic [WIDTH-1:0] w_plo, w_phi;
  assign w_ma   = {{2{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
  assign w_mb   = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
  assign w_trip = {r_lo[1:0], r_g};
  assign w_zero = (w_trip == 3'b000) || (w_trip == 3'b111);
  assign w_neg  = w_trip[2];
  assign w_two  = (w_trip == 3'b011) || (w_trip == 3'b100);
  assign w_sel  = w_two ? {r_m[EW-2:0], 1'b0} : r_m;
  assign w_add  = w_zero ? '0 : (w_neg ? ~w_sel : w_sel);
  assign w_sum  = r_hi + w_add + EW'(w_neg & ~w_zero);
  assign w_hi   = {{2{w_sum[EW-1]}}, w_sum[EW-1:2]};
  assign w_lo   = {w_sum[1:0], r_lo[EW-1:2]};
  // low 2*WIDTH bits of {hi, lo} after the final shift
  assign w_plo  = w_lo[WIDTH-1:0];
  assign w_phi  = {w_hi[WIDTH-3:0], w_lo[EW-1:WIDTH]};
  assign w_ovf  = r_signed ? (w_phi != {WIDTH{w_plo[WIDTH-1]}}) : (w_phi != '0);
  assign w_last = r_cnt == CW'(N - 1);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.start) w_next = CALC;
    if (r_state == CALC && w_last) w_next = DONE;
    if (r_state == DONE) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_g      <= 1'b0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_plo    <= '0;
      r_phi    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_hi     <= '0;
        r_lo     <= w_mb;
        r_g      <= 1'b0;
        r_m      <= w_ma;
        r_signed <= bus.is_signed;
        r_cnt    <= '0;
      end else if (r_state == CALC) begin
        r_hi  <= w_hi;
        r_lo  <= w_lo;
        r_g   <= r_lo[1];
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_plo <= w_plo;
          r_phi <= w_phi;
          r_ovf <= w_ovf;
        end
      end
    end
  end
  assign bus.busy         = r_state != IDLE;
  assign bus.result_ready = r_state == DONE;
  assign bus.product_lo   = r_plo;
  assign bus.product_hi   = r_phi;
  assign bus.overflow     = r_ovf;
endmodule
